// File: rtl/cache_pkg.sv
// Shared cache geometry and burst FSM encoding.
// The address decoder imports the same constants, so field positions stay aligned.
package cache_pkg;

   localparam int ADDR_W         = 16;
   localparam int INDEX_W        = 5;
   localparam int OFFSET_W       = 5;
   localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
   localparam int WSEL_W         = OFFSET_W - 2;
   localparam int WORDS_PER_LINE = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/line_addr_pack.sv
// Composes a word-aligned byte address from {tag, index, word}.
// This is the exact inverse of the cache address decoder.
module line_addr_pack
   import cache_pkg::*;
(
   input  logic [TAG_W-1:0]   tag,
   input  logic [INDEX_W-1:0] index,
   input  logic [WSEL_W-1:0]  word,
   output logic [ADDR_W-1:0]  addr
);

   assign addr = {tag, index, word, {(OFFSET_W - WSEL_W){1'b0}}};

endmodule

// File: rtl/line_addr_gen.sv
// Critical-word-first burst address generator for cache line refill/writeback.
// Accepts {tag, index, word} from the controller and emits 8 wrapping beat addresses.
module line_addr_gen
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [TAG_W-1:0]   req_tag,
   input  logic [INDEX_W-1:0] req_index,
   input  logic [WSEL_W-1:0]  req_word,
   input  logic               req_write,
   input  logic               abort,
   output logic               mem_valid,
   input  logic               mem_ready,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [WSEL_W-1:0]  mem_word,
   output logic               mem_write,
   output logic               mem_last,
   output logic               done
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // valid never waits on ready, and a presented beat holds stable until it transfers.

   state_t               state_q, state_d;
   logic [TAG_W-1:0]     tag_q;
   logic [INDEX_W-1:0]   index_q;
   logic [WSEL_W-1:0]    start_q;
   logic [WSEL_W-1:0]    cnt_q;
   logic                 write_q;
   logic [WSEL_W-1:0]    word_cur;
   logic [ADDR_W-1:0]    addr_cur;
   logic                 accept;
   logic                 beat;
   logic                 cnt_last;

   // Natural WSEL_W-bit overflow gives the wrap inside the line.
   assign word_cur = start_q + cnt_q;
   assign cnt_last = (cnt_q == WSEL_W'(WORDS_PER_LINE - 1));

   line_addr_pack u_pack (
      .tag   (tag_q),
      .index (index_q),
      .word  (word_cur),
      .addr  (addr_cur)
   );

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_word  = '0;
      mem_last  = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      beat      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            accept    = req_valid;
            if (req_valid) state_d = BURST;
         end
         BURST: begin
            mem_valid = 1'b1;
            mem_addr  = addr_cur;
            mem_word  = word_cur;
            mem_last  = cnt_last;
            // abort wins over a same-cycle handshake
            beat      = mem_ready && !abort;
            if (abort)               state_d = IDLE;
            else if (beat && cnt_last) state_d = DONE;
         end
         DONE: begin
            done    = !abort;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tag_q   <= '0;
         index_q <= '0;
         start_q <= '0;
         write_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            tag_q   <= req_tag;
            index_q <= req_index;
            start_q <= req_word;
            write_q <= req_write;
            cnt_q   <= '0;
         end else if (beat) begin
            cnt_q <= cnt_q + WSEL_W'(1);
         end
      end
   end

   assign mem_write = write_q;

endmodule

// File: doc/line_addr_gen.md
Name: line_addr_gen

Overview:
Burst address generator for cache line refill and writeback to main memory. It is the inverse of the address decoder: it takes {tag, index, starting word} and composes the full byte address for every word of the line. Word order is critical-word-first with wrap-around inside the line. It sits between the cache controller FSM (request side) and the main-memory port (beat side).

Parameters:
ADDR_W, 16, full byte address width
INDEX_W, 5, set index width
OFFSET_W, 5, line offset width (32-byte line)
TAG_W, ADDR_W-INDEX_W-OFFSET_W (=6), tag width, derived, not overridable
WSEL_W, OFFSET_W-2 (=3), word select width (32-bit words), derived

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  controller requests a line burst
req_ready  out  1  high only in IDLE; a request is accepted on req_valid && req_ready
req_tag  in  TAG_W  tag of the line
req_index  in  INDEX_W  set index of the line
req_word  in  WSEL_W  first (critical) word
req_write  in  1  1 = writeback, 0 = refill; registered and passed through
abort  in  1  synchronous burst cancel
mem_valid  out  1  beat address valid
mem_ready  in  1  memory accepts the beat
mem_addr  out  ADDR_W  {tag, index, word, 2'b00}
mem_word  out  WSEL_W  word select of the current beat
mem_write  out  1  registered req_write
mem_last  out  1  current beat is the 8th
done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - mem_valid=0, mem_addr=0, mem_word=0, mem_write=0, mem_last=0, done=0.
  - Beat counter = 0.
  - req_ready=1, because it is decoded from the IDLE state.
- FSM states are IDLE, BURST and DONE.
- IDLE:
  - On accept, register tag, index, req_word and req_write, and clear the counter.
  - Next state is BURST. mem_valid rises the cycle after accept (latency 1).
- BURST:
  - mem_word = (start_word + cnt) mod 2^WSEL_W, with natural 3-bit wrap.
  - mem_addr is composed from the registered fields; byte bits are always 00.
  - A beat completes on mem_valid && mem_ready; cnt then increments and the next address appears the following cycle.
  - While mem_ready=0, mem_valid, mem_addr, mem_word and mem_last hold stable.
  - mem_last = (cnt == 7).
  - Completing the beat with cnt == 7 moves to DONE; mem_valid drops the same edge.
- DONE:
  - done=1 for exactly one cycle, then IDLE. req_ready=0 during DONE.
- abort:
  - Has priority over a beat handshake in the same cycle.
  - In BURST or DONE it forces IDLE next cycle, drops mem_valid, and produces no done pulse.
  - Ignored in IDLE.
- req_valid outside IDLE: ignored, not queued. The controller must hold the request until req_ready.
- Fields of a request are sampled only on the accept cycle; later changes have no effect.
- Reset mid-burst: immediate return to reset values, no done. The first request after reset release is accepted normally.
- Throughput: 8 beats in 8 cycles with mem_ready held high. Total accept-to-done is 10 cycles.

Decomposition:
- Package cache_pkg holds:
  - ADDR_W, INDEX_W, OFFSET_W, TAG_W, WSEL_W;
  - WORDS_PER_LINE = 8;
  - the state enum {IDLE, BURST, DONE}.
- The address decoder and this block import the same constants, so field positions cannot diverge.
- One sub-module, line_addr_pack: combinational {tag, index, word} -> byte address. It is the exact inverse of the decoder and is unit-testable against it round-trip.

Test Plan:
1. Basic refill: tag=0x2A, index=0x13, word=0, mem_ready=1 -> addresses 0xAA60, 0xAA64, ..., 0xAA7C on consecutive cycles; mem_last only on 0xAA7C; done pulses 1 cycle later; total 10 cycles.
2. Wrap: tag=0x3F, index=0x1F, word=5 -> 0xFFF4, 0xFFF8, 0xFFFC, 0xFFE0, 0xFFE4, 0xFFE8, 0xFFEC, 0xFFF0 (last).
3. Backpressure: case 1 with mem_ready=0 for 3 cycles at beat 2 -> mem_addr held at 0xAA68 with mem_valid=1; sequence resumes unchanged; done is 3 cycles later than in case 1.
4. Abort/reset: abort asserted at beat 4 together with mem_ready=1 -> IDLE next cycle, no done. Repeat the burst with rst pulsed at beat 3 -> all outputs 0 immediately, req_ready=1.
5. Busy request: second req_valid during BURST -> not accepted. The held request is accepted the cycle after done; its mem_write reflects the new req_write=1.
6. Round-trip: random {tag, index, word} -> mem_addr fed into the decoder returns the same fields for 1000 samples.
